// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-Lite encodings and the default-slave state type.
// Contents: htrans_t (IDLE/BUSY/NONSEQ/SEQ), hresp_t (OKAY/ERROR), ds_state_t (IDLE/ERR1/ERR2).
package ahb_lite_pkg;
   typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
   typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} hresp_t;
   typedef enum logic [1:0] {DS_IDLE = 2'b00, DS_ERR1 = 2'b01, DS_ERR2 = 2'b10} ds_state_t;
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR sequencer for unmapped transfers and watchdog-terminated waits.
// Ports: clk, reset (async active-low); i_ready = bus HREADY; i_new_err = address phase is an active
// unmapped transfer; i_wait = active mapped data phase with its slave not ready; o_err1/o_err2 flag the
// ERR1/ERR2 cycles; o_timeout_evt pulses in the ERR1 cycle of a watchdog termination.
module ahb_default_slave
   import ahb_lite_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
)(
   input  logic clk,
   input  logic reset,
   input  logic i_ready,
   input  logic i_new_err,
   input  logic i_wait,
   output logic o_err1,
   output logic o_err2,
   output logic o_timeout_evt
);
   localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYC);
   ds_state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic w_fire;
   // Timeout ERR1 is combinational so a slave ready on the limit cycle still wins.
   assign w_fire = (TIMEOUT_CYC != 0) && (r_state == DS_IDLE) && i_wait && (r_cnt == CMAX);
   assign o_err1 = (r_state == DS_ERR1) || w_fire;
   assign o_err2 = (r_state == DS_ERR2);
   assign o_timeout_evt = w_fire;
   always_comb begin
      w_next = DS_IDLE;
      if (o_err1) w_next = DS_ERR2;
      else if (i_ready && i_new_err) w_next = DS_ERR1;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= DS_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (i_ready) r_cnt <= '0;
         else if (i_wait && r_cnt != CMAX) r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/ahb_lite_interconnect.sv
// ahb_lite_interconnect: single-master AHB-Lite decoder and response mux with default slave and watchdog.
// Ports: clk, reset (async active-low); HADDR/HTRANS master address phase; HSEL one-hot slave select
// (HADDR[31:28] = slave index); HRDATA_S/HREADYOUT_S/HRESP_S packed slave responses;
// HRDATA/HREADY/HRESP muxed response; timeout_evt watchdog pulse.
module ahb_lite_interconnect
   import ahb_lite_pkg::*;
#(
   parameter int NUM_SLAVES  = 3,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [31:0]                  HADDR,
   input  logic [1:0]                   HTRANS,
   output logic [NUM_SLAVES-1:0]        HSEL,
   input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]        HRESP_S,
   output logic [DATA_W-1:0]            HRDATA,
   output logic                         HREADY,
   output logic                         HRESP,
   output logic                         timeout_evt
);
   logic [3:0] r_idx;
   logic r_active;
   logic w_act, w_hit, w_mapped, w_err1, w_err2;
   logic [DATA_W-1:0] w_s_rdata;
   logic w_s_ready, w_s_resp;
   logic w_unused;
   assign w_unused = ^HADDR[27:0];
   assign w_act    = (HTRANS == HT_NONSEQ) || (HTRANS == HT_SEQ);
   assign w_hit    = HADDR[31:28] < 4'(NUM_SLAVES);
   assign w_mapped = r_idx < 4'(NUM_SLAVES);
   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_sel
      assign HSEL[g] = (HADDR[31:28] == 4'(g));
   end
   always_comb begin
      w_s_rdata = '0;
      w_s_ready = 1'b1;
      w_s_resp  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_idx == 4'(i)) begin
            w_s_rdata = HRDATA_S[i*DATA_W +: DATA_W];
            w_s_ready = HREADYOUT_S[i];
            w_s_resp  = HRESP_S[i];
         end
      end
   end
   // Error sequencer overrides the selected slave, including a timed-out mapped one.
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = RESP_OKAY;
      if (w_err1) begin
         HREADY = 1'b0;
         HRESP  = RESP_ERROR;
      end else if (w_err2) HRESP = RESP_ERROR;
      else if (r_active && w_mapped) begin
         HRDATA = w_s_rdata;
         HREADY = w_s_ready;
         HRESP  = w_s_resp;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx    <= '0;
         r_active <= 1'b0;
      end else if (HREADY) begin
         r_idx    <= HADDR[31:28];
         r_active <= w_act;
      end
   end
   ahb_default_slave #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_def (
      .clk          (clk),
      .reset        (reset),
      .i_ready      (HREADY),
      .i_new_err    (w_act && !w_hit),
      .i_wait       (r_active && w_mapped && !w_s_ready),
      .o_err1       (w_err1),
      .o_err2       (w_err2),
      .o_timeout_evt(timeout_evt)
   );
endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// tb_ahb_lite_interconnect: directed scoreboard bench; stimulus queues expected per-cycle responses, a negedge monitor compares.
module tb_ahb_lite_interconnect;
   import ahb_lite_pkg::*;
   typedef struct packed {
      logic [63:0] nm;
      logic [2:0]  hs;
      logic        rdy;
      logic        rsp;
      logic [31:0] d;
      logic        te;
   } exp_t;
   logic clk = 1'b0;
   logic reset;
   logic [31:0] HADDR;
   logic [1:0] HTRANS;
   logic [2:0] HSEL;
   logic [95:0] HRDATA_S;
   logic [2:0] HREADYOUT_S, HRESP_S;
   logic [31:0] HRDATA;
   logic HREADY, HRESP, timeout_evt;
   exp_t q[$];
   int total = 0;
   int bad = 0;
   localparam logic [31:0] D0 = 32'hA0A0_A0A0, D1 = 32'hB1B1_B1B1, D2 = 32'hC2C2_C2C2;
   ahb_lite_interconnect #(.NUM_SLAVES(3), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL),
      .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .timeout_evt(timeout_evt)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total++;
         if (HSEL !== e.hs || HREADY !== e.rdy || HRESP !== e.rsp || HRDATA !== e.d || timeout_evt !== e.te) begin
            bad++;
            $display("FAIL %s: got sel=%b rdy=%b rsp=%b data=%h evt=%b, want sel=%b rdy=%b rsp=%b data=%h evt=%b",
                     e.nm, HSEL, HREADY, HRESP, HRDATA, timeout_evt, e.hs, e.rdy, e.rsp, e.d, e.te);
         end
      end
   end
   task automatic chk(input logic [63:0] nm, input logic [2:0] hs, input logic rdy, input logic rsp,
                      input logic [31:0] d, input logic te);
      q.push_back('{nm, hs, rdy, rsp, d, te});
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_s(input logic [2:0] rdy, input logic [2:0] rsp, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] d2);
      HREADYOUT_S = rdy;
      HRESP_S = rsp;
      HRDATA_S = {d2, d1, d0};
   endtask
   task automatic drv(input logic [31:0] a, input htrans_t t);
      HADDR = a;
      HTRANS = t;
   endtask
   initial begin
      reset = 1'b0;
      drv(32'h3000_0000, HT_IDLE);
      set_s(3'b111, 3'b000, D0, D1, D2);
      tick();
      chk("rst", 3'b000, 1, 0, 0, 0); tick();
      reset = 1'b1;
      chk("idle", 3'b000, 1, 0, 0, 0); tick();
      drv(32'h1000_0004, HT_NONSEQ);
      chk("a_s1", 3'b010, 1, 0, 0, 0); tick();
      drv(32'h3000_0000, HT_IDLE);
      set_s(3'b101, 3'b000, D0, D1, D2);
      chk("w1", 3'b000, 0, 0, D1, 0); tick();
      chk("w2", 3'b000, 0, 0, D1, 0); tick();
      set_s(3'b111, 3'b000, D0, 32'hDEAD_BEEF, D2);
      chk("rd", 3'b000, 1, 0, 32'hDEAD_BEEF, 0); tick();
      set_s(3'b111, 3'b000, D0, D1, D2);
      chk("idl2", 3'b000, 1, 0, 0, 0); tick();
      drv(32'h0000_0010, HT_NONSEQ);
      chk("a_s0", 3'b001, 1, 0, 0, 0); tick();
      drv(32'h3000_0000, HT_IDLE);
      set_s(3'b110, 3'b001, D0, D1, D2);
      chk("sresp1", 3'b000, 0, 1, D0, 0); tick();
      set_s(3'b111, 3'b001, D0, D1, D2);
      chk("sresp2", 3'b000, 1, 1, D0, 0); tick();
      set_s(3'b111, 3'b000, D0, D1, D2);
      drv(32'hF000_0000, HT_IDLE);
      chk("u_idle", 3'b000, 1, 0, 0, 0); tick();
      drv(32'hF000_0000, HT_BUSY);
      chk("u_idle2", 3'b000, 1, 0, 0, 0); tick();
      drv(32'hF000_0000, HT_NONSEQ);
      chk("u_busy", 3'b000, 1, 0, 0, 0); tick();
      drv(32'hE000_0000, HT_NONSEQ);
      chk("e1a", 3'b000, 0, 1, 0, 0); tick();
      chk("e2a", 3'b000, 1, 1, 0, 0); tick();
      drv(32'h3000_0000, HT_IDLE);
      chk("e1b", 3'b000, 0, 1, 0, 0); tick();
      chk("e2b", 3'b000, 1, 1, 0, 0); tick();
      chk("idl3", 3'b000, 1, 0, 0, 0); tick();
      drv(32'h2000_0000, HT_NONSEQ);
      chk("a_s2", 3'b100, 1, 0, 0, 0); tick();
      drv(32'h3000_0000, HT_IDLE);
      set_s(3'b011, 3'b000, D0, D1, D2);
      for (int i = 0; i < 16; i++) begin
         chk("wd_wait", 3'b000, 0, 0, D2, 0); tick();
      end
      chk("to_err1", 3'b000, 0, 1, 0, 1); tick();
      chk("to_err2", 3'b000, 1, 1, 0, 0); tick();
      chk("to_idle", 3'b000, 1, 0, 0, 0); tick();
      set_s(3'b111, 3'b000, D0, D1, D2);
      drv(32'h0000_0000, HT_NONSEQ);
      chk("a_s0b", 3'b001, 1, 0, 0, 0); tick();
      drv(32'h3000_0000, HT_IDLE);
      set_s(3'b110, 3'b000, D0, D1, D2);
      for (int i = 0; i < 16; i++) begin
         chk("s0_wait", 3'b000, 0, 0, D0, 0); tick();
      end
      set_s(3'b111, 3'b000, 32'h1234_5678, D1, D2);
      chk("s0_win", 3'b000, 1, 0, 32'h1234_5678, 0); tick();
      set_s(3'b111, 3'b000, D0, D1, D2);
      chk("idl5", 3'b000, 1, 0, 0, 0); tick();
      drv(32'hF000_0000, HT_NONSEQ);
      chk("a_unm", 3'b000, 1, 0, 0, 0); tick();
      drv(32'h3000_0000, HT_IDLE);
      #1 reset = 1'b0;
      chk("rst_e1", 3'b000, 1, 0, 0, 0); tick();
      chk("rst_noe2", 3'b000, 1, 0, 0, 0); tick();
      reset = 1'b1;
      chk("rel", 3'b000, 1, 0, 0, 0); tick();
      drv(32'h1000_0000, HT_NONSEQ);
      chk("a_rel", 3'b010, 1, 0, 0, 0); tick();
      drv(32'h3000_0000, HT_IDLE);
      set_s(3'b111, 3'b000, D0, 32'hCAFE_F00D, D2);
      chk("rd_rel", 3'b000, 1, 0, 32'hCAFE_F00D, 0); tick();
      set_s(3'b111, 3'b000, D0, D1, D2);
      chk("idl6", 3'b000, 1, 0, 0, 0); tick();
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
